// File: rtl/vga_frame_buffer.sv
`timescale 1ns/1ps
// Double-buffered 160x120x8 frame store feeding the VGA timing block.
// Display reads the front bank; CPU writes and the hardware fill target the back bank.
module vga_frame_buffer #(
  parameter int unsigned H_RES         = 160,
  parameter int unsigned V_RES         = 120,
  parameter int unsigned SCALE_SHIFT   = 2,
  parameter int unsigned VIS_H         = 640,
  parameter int unsigned VIS_V         = 480,
  parameter logic [7:0]  BORDER_COLOUR = 8'h00
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [9:0] VGA_ADDRH,
  input  logic [9:0] VGA_ADDRV,
  input  logic       VGA_VS,
  output logic [7:0] COLOUR_OUT,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [7:0] WR_X,
  input  logic [6:0] WR_Y,
  input  logic [7:0] WR_DATA,
  input  logic       FILL_REQ,
  input  logic [7:0] FILL_COLOUR,
  input  logic       SWAP_REQ,
  output logic       BUSY,
  output logic       SWAP_PENDING,
  output logic       FRONT_SEL
);

  localparam int unsigned NPIX = H_RES * V_RES;
  localparam int unsigned AW   = $clog2(NPIX);

  localparam logic [AW-1:0] H_RES_A   = AW'(H_RES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [7:0]    H_RES_X   = 8'(H_RES);
  localparam logic [6:0]    V_RES_Y   = 7'(V_RES);
  localparam logic [9:0]    VIS_H_W   = 10'(VIS_H);
  localparam logic [9:0]    VIS_V_W   = 10'(VIS_V);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e          state_q;
  logic            busy_q;
  logic [AW-1:0]   fill_cnt_q;
  logic [7:0]      fill_colour_q;
  logic            front_sel_q;
  logic            swap_pending_q;
  logic            vs_d_q;
  logic            border_q;
  logic            rd_sel_q;
  logic [7:0]      rd0_q;
  logic [7:0]      rd1_q;

  logic [7:0]      mem0 [NPIX];
  logic [7:0]      mem1 [NPIX];

  // Display read address: screen pixel downscaled to buffer pixel.
  logic          visible;
  logic [AW-1:0] rd_addr;
  assign visible = (VGA_ADDRH < VIS_H_W) && (VGA_ADDRV < VIS_V_W);
  assign rd_addr = AW'(VGA_ADDRV >> SCALE_SHIFT) * H_RES_A + AW'(VGA_ADDRH >> SCALE_SHIFT);

  logic          wr_fire;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;
  assign WR_READY    = (state_q == StIdle) && !FILL_REQ && RESETn;
  assign wr_fire     = WR_VALID && WR_READY;
  assign wr_in_range = (WR_X < H_RES_X) && (WR_Y < V_RES_Y);
  assign wr_addr     = AW'(WR_Y) * H_RES_A + AW'(WR_X);

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = WR_DATA;
    if (state_q == StFill) begin
      mem_we    = 1'b1;
      mem_waddr = fill_cnt_q;
      mem_wdata = fill_colour_q;
    end else if (wr_fire && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Bank 0 is the back bank when bank 1 is displayed, and vice versa.
  always_ff @(posedge CLK) begin
    if (mem_we && front_sel_q) mem0[mem_waddr] <= mem_wdata;
    if (visible) rd0_q <= mem0[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !front_sel_q) mem1[mem_waddr] <= mem_wdata;
    if (visible) rd1_q <= mem1[rd_addr];
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      border_q <= 1'b1;
      rd_sel_q <= 1'b0;
    end else begin
      border_q <= !visible;
      rd_sel_q <= front_sel_q;
    end
  end

  assign COLOUR_OUT = border_q ? BORDER_COLOUR : (rd_sel_q ? rd1_q : rd0_q);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      fill_cnt_q    <= '0;
      fill_colour_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (FILL_REQ) begin
            state_q       <= StFill;
            busy_q        <= 1'b1;
            fill_cnt_q    <= '0;
            fill_colour_q <= FILL_COLOUR;
          end
        end
        StFill: begin
          if (fill_cnt_q == LAST_ADDR) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Swap only at VS start and never mid-fill, so the fill always lands in one bank.
  logic vs_fall;
  assign vs_fall = vs_d_q && !VGA_VS;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vs_d_q         <= 1'b1;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      vs_d_q <= VGA_VS;
      if (vs_fall && (swap_pending_q || SWAP_REQ) && (state_q == StIdle)) begin
        front_sel_q    <= !front_sel_q;
        swap_pending_q <= 1'b0;
      end else if (SWAP_REQ) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  assign BUSY         = busy_q;
  assign SWAP_PENDING = swap_pending_q;
  assign FRONT_SEL    = front_sel_q;

endmodule

// File: tb/tb_vga_frame_buffer.sv
`timescale 1ns/1ps
// Directed bench for vga_frame_buffer: fill, swap timing, downscaled reads, border,
// out-of-range writes and asynchronous reset mid-fill.
module tb_vga_frame_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] vga_addrh;
  logic [9:0] vga_addrv;
  logic       vga_vs;
  logic [7:0] colour_out;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_data;
  logic       fill_req;
  logic [7:0] fill_colour;
  logic       swap_req;
  logic       busy;
  logic       swap_pending;
  logic       front_sel;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  vga_frame_buffer dut (
    .CLK          (clk),
    .RESETn       (rst_n),
    .VGA_ADDRH    (vga_addrh),
    .VGA_ADDRV    (vga_addrv),
    .VGA_VS       (vga_vs),
    .COLOUR_OUT   (colour_out),
    .WR_VALID     (wr_valid),
    .WR_READY     (wr_ready),
    .WR_X         (wr_x),
    .WR_Y         (wr_y),
    .WR_DATA      (wr_data),
    .FILL_REQ     (fill_req),
    .FILL_COLOUR  (fill_colour),
    .SWAP_REQ     (swap_req),
    .BUSY         (busy),
    .SWAP_PENDING (swap_pending),
    .FRONT_SEL    (front_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and retire any outstanding read expectation.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("colour", {24'd0, colour_out}, {24'd0, e});
    end
  endtask

  task automatic rd(input int h, input int v, input logic [7:0] e);
    vga_addrh = 10'(h);
    vga_addrv = 10'(v);
    exp_q.push_back(e);
    step();
  endtask

  task automatic wr(input int x, input int y, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_x     = 8'(x);
    wr_y     = 7'(y);
    wr_data  = d;
    #1;
    check("wr_ready_handshake", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic vs_pulse();
    vga_vs = 1'b0;
    step();
    vga_vs = 1'b1;
    step();
  endtask

  task automatic request_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("pending_after_req", {31'd0, swap_pending}, 32'd1);
    vs_pulse();
    check("pending_after_swap", {31'd0, swap_pending}, 32'd0);
  endtask

  task automatic fill_run(input logic [7:0] c, input bit with_swap, input int stop_at,
                          output int n, output int rdy_seen);
    fill_req    = 1'b1;
    fill_colour = c;
    #1;
    check("wr_ready_at_fill_req", {31'd0, wr_ready}, 32'd0);
    step();
    fill_req = 1'b0;
    wr_valid = 1'b0;
    n        = 0;
    rdy_seen = 0;
    while (busy === 1'b1 && n < stop_at) begin
      if (wr_ready !== 1'b0) rdy_seen++;
      n++;
      swap_req = with_swap && (n == 100 || n == 200);
      vga_vs   = !(with_swap && n == 300);
      step();
    end
    swap_req = 1'b0;
    vga_vs   = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int rdy_seen;
    rst_n       = 1'b0;
    vga_addrh   = '0;
    vga_addrv   = '0;
    vga_vs      = 1'b1;
    wr_valid    = 1'b0;
    wr_x        = '0;
    wr_y        = '0;
    wr_data     = '0;
    fill_req    = 1'b0;
    fill_colour = '0;
    swap_req    = 1'b0;

    step();
    step();
    check("rst_front_sel", {31'd0, front_sel}, 32'd0);
    check("rst_pending", {31'd0, swap_pending}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_colour", {24'd0, colour_out}, 32'h00);
    rst_n = 1'b1;
    #1;
    check("wr_ready_after_rst", {31'd0, wr_ready}, 32'd1);
    step();

    // Fill back bank 1 with E0, display it.
    fill_run(8'hE0, 1'b0, 30000, n, rdy_seen);
    check("fill_busy_cycles", n, 19200);
    check("fill_wr_ready_low", rdy_seen, 0);
    check("busy_after_fill", {31'd0, busy}, 32'd0);
    request_swap();
    check("front_after_swap1", {31'd0, front_sel}, 32'd1);
    rd(0, 0, 8'hE0);
    rd(639, 479, 8'hE0);
    rd(320, 240, 8'hE0);

    // Fill bank 0 with 5A; swap requested and VS falls during the fill.
    fill_run(8'h5A, 1'b1, 30000, n, rdy_seen);
    check("fill2_busy_cycles", n, 19200);
    check("front_held_during_fill", {31'd0, front_sel}, 32'd1);
    check("pending_held_during_fill", {31'd0, swap_pending}, 32'd1);
    vs_pulse();
    check("front_deferred_swap", {31'd0, front_sel}, 32'd0);
    check("pending_deferred_swap", {31'd0, swap_pending}, 32'd0);
    vs_pulse();
    check("front_single_swap", {31'd0, front_sel}, 32'd0);
    rd(0, 0, 8'h5A);
    rd(639, 479, 8'h5A);

    // Single pixel into bank 1, then display it.
    wr(10, 5, 8'h3C);
    request_swap();
    check("front_after_swap3", {31'd0, front_sel}, 32'd1);
    for (int v = 20; v < 24; v++)
      for (int h = 40; h < 44; h++)
        rd(h, v, 8'h3C);
    rd(44, 20, 8'hE0);
    rd(39, 20, 8'hE0);

    // Border region.
    rd(640, 0, 8'h00);
    rd(0, 480, 8'h00);
    rd(1023, 1023, 8'h00);
    rd(639, 479, 8'hE0);

    // Out-of-range writes into bank 0 are accepted and dropped.
    wr(160, 0, 8'hFF);
    wr(0, 120, 8'hFF);
    request_swap();
    check("front_after_swap4", {31'd0, front_sel}, 32'd0);
    for (int h = 0; h < 640; h += 4) rd(h, 0, 8'h5A);
    rd(0, 4, 8'h5A);
    request_swap();
    check("front_after_swap5", {31'd0, front_sel}, 32'd1);

    // Fill wins over a same-cycle write; reset lands mid-fill.
    wr_valid = 1'b1;
    wr_x     = 8'd1;
    wr_y     = 7'd1;
    wr_data  = 8'h11;
    fill_run(8'h77, 1'b1, 5000, n, rdy_seen);
    check("mid_fill_count", n, 5000);
    check("mid_fill_busy", {31'd0, busy}, 32'd1);
    check("mid_fill_pending", {31'd0, swap_pending}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_front", {31'd0, front_sel}, 32'd0);
    check("async_rst_pending", {31'd0, swap_pending}, 32'd0);
    check("async_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("async_rst_colour", {24'd0, colour_out}, 32'h00);
    step();
    rst_n = 1'b1;
    #1;
    check("wr_ready_after_rst2", {31'd0, wr_ready}, 32'd1);
    step();
    step();
    check("busy_after_rst2", {31'd0, busy}, 32'd0);
    check("wr_ready_idle", {31'd0, wr_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_frame_buffer.md
Name: vga_frame_buffer

Overview:
Double-buffered 160x120x8-bit pixel store that sits directly upstream of the VGA timing interface. It converts the interface's 640x480 pixel address (addrh/addrv) into a 4x-downscaled buffer address and returns the 8-bit colour that drives COLOUR_IN. The CPU/bus side draws into the back buffer through a valid/ready write port, can hardware-fill the back buffer with one colour, and requests a front/back swap that takes effect only at the start of vertical sync.

Parameters:
H_RES, 160, buffer width in pixels
V_RES, 120, buffer height in pixels
SCALE_SHIFT, 2, log2 of the upscale factor from buffer pixels to screen pixels
VIS_H, 640, visible screen width; addrh >= VIS_H is border
VIS_V, 480, visible screen height; addrv >= VIS_V is border
BORDER_COLOUR, 8'h00, colour output outside the visible area

Ports:
CLK  in  1  single system clock; all logic is in this domain
RESETn  in  1  asynchronous, active-low reset
VGA_ADDRH  in  10  horizontal pixel address from the VGA interface
VGA_ADDRV  in  10  vertical pixel address from the VGA interface
VGA_VS  in  1  vertical sync from the VGA interface, active low, synchronous to CLK
COLOUR_OUT  out  8  pixel colour to the VGA interface COLOUR_IN
WR_VALID  in  1  pixel write request
WR_READY  out  1  write accepted when WR_VALID && WR_READY
WR_X  in  8  write x coordinate, 0..H_RES-1
WR_Y  in  7  write y coordinate, 0..V_RES-1
WR_DATA  in  8  write colour
FILL_REQ  in  1  single-cycle pulse: fill the back buffer with FILL_COLOUR
FILL_COLOUR  in  8  fill colour, sampled in the FILL_REQ cycle
SWAP_REQ  in  1  single-cycle pulse: swap front and back at the next VS start
BUSY  out  1  fill in progress
SWAP_PENDING  out  1  swap requested but not yet performed
FRONT_SEL  out  1  bank currently displayed (0 or 1)

Behaviour:
- Storage: two banks of H_RES*V_RES bytes (19200 each). Linear address = y*H_RES + x, 15 bits. Contents are not cleared by reset.
- Read path: bx = VGA_ADDRH>>SCALE_SHIFT, by = VGA_ADDRV>>SCALE_SHIFT. The front bank is read synchronously.
- COLOUR_OUT is registered and valid exactly 1 CLK after the address is presented.
- If VGA_ADDRH >= VIS_H or VGA_ADDRV >= VIS_V, COLOUR_OUT = BORDER_COLOUR. The border flag is pipelined so it stays aligned with the same 1-cycle latency.
- Writes always target the back bank (~FRONT_SEL), as sampled in the handshake cycle.
- WR_READY = (state==IDLE) && !FILL_REQ && RESETn.
- A coordinate with WR_X >= H_RES or WR_Y >= V_RES is still accepted (handshake completes) but dropped; memory is unchanged.
- FSM states:
  - IDLE: FILL_REQ latches FILL_COLOUR, clears the fill counter, and moves to FILL. FILL_REQ has priority over a same-cycle WR_VALID, which is not accepted that cycle.
  - FILL: writes one pixel per cycle to the back bank at addresses 0..19199. BUSY=1 and WR_READY=0. After the write to 19199 (19200 cycles) it returns to IDLE. FILL_REQ in FILL is ignored.
- Swap:
  - SWAP_REQ sets SWAP_PENDING.
  - The VS falling edge is detected using a vs_d register (reset value 1): edge = vs_d && !VGA_VS.
  - On an edge with SWAP_PENDING=1 (or SWAP_REQ=1 in the same cycle) and state==IDLE, FRONT_SEL toggles and SWAP_PENDING clears.
  - If state==FILL at the edge, the swap is deferred to the first VS falling edge after the fill completes.
  - Repeated SWAP_REQ while pending has no further effect; there is exactly one swap per pending request.
- Reset (asynchronous, any time including mid-fill): state=IDLE, BUSY=0, WR_READY=0 while RESETn=0, FRONT_SEL=0, SWAP_PENDING=0, COLOUR_OUT=BORDER_COLOUR, vs_d=1. A fill in progress is aborted; partially filled contents remain.

Test Plan:
- Reset; write (10,5)=8'h3C with one-cycle handshake; SWAP_REQ; pulse VGA_VS low -> FRONT_SEL=1. Then present addrh 40..43, addrv 20..23 -> COLOUR_OUT=8'h3C one CLK after each address; neighbouring addrh 44 returns the prior contents.
- addrh=640, addrv=0, and addrh=0, addrv=480 -> COLOUR_OUT=8'h00 one CLK later, regardless of memory contents.
- FILL_REQ with FILL_COLOUR=8'hE0 -> BUSY=1 and WR_READY=0 for exactly 19200 cycles. After a swap, sampled addresses (0,0), (639,479), (320,240) -> 8'hE0.
- SWAP_REQ during a fill, with a VS falling edge during the fill -> FRONT_SEL unchanged and SWAP_PENDING=1. At the first VS fall after BUSY drops -> FRONT_SEL toggles and SWAP_PENDING=0.
- Write WR_X=160, WR_Y=0, WR_DATA=8'hFF -> accepted in one cycle; read-back of the whole row 0 is unchanged. FILL_REQ and WR_VALID in the same cycle -> write not accepted, fill starts.
- Assert RESETn=0 mid-fill at count ~5000 -> BUSY=0 and FRONT_SEL=0 immediately (asynchronous). After release, WR_READY=1 and the FSM is in IDLE.
